key_input_conditioner: RTL and testbench

//  Front end for the combination-lock FSM. Conditions the two raw push-buttons and the
//  4-bit password switches from the board before they reach the FSM.
//  Per button: 2-FF synchronizer, debounce state machine, then exactly one 1-cycle pulse per press.
//  The password switches are synchronized and latched on each pulse, so Password is stable

---
 rtl/key_input_conditioner.sv | 134 +++++++++++++
 tb/tb_key_input_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronizes and debounces two push-buttons, emits one
// registered pulse per accepted press, and latches the password switches on
// that pulse so the lock FSM always samples a stable Password with Key1/Key2.
module key_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Key1_raw,
   input  logic       Key2_raw,
   input  logic [3:0] Password_raw,
   output logic       Key1,
   output logic       Key2,
   output logic [3:0] Password,
   output logic       Conflict
);

   localparam int NUM_KEYS = 2;

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] acc;     // registered: press accepted on the previous edge
   logic [3:0]          pw_s1;
   logic [3:0]          pw_s2;

   assign key_raw = {Key2_raw, Key1_raw};

   genvar g;
   generate
      for (g = 0; g < NUM_KEYS; g++) begin : g_key
         logic             s1;
         logic             s2;
         logic [1:0]       state;
         logic [CNT_W-1:0] cnt;
         logic             acc_q;

         // Per-key synchronizer, debounce FSM and accept flag. The accept is
         // registered on the PRESS_WAIT->PRESSED edge; the output stage adds one
         // more edge so Key and Password move together.
         always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
               s1    <= 1'b0;
               s2    <= 1'b0;
               state <= IDLE;
               cnt   <= '0;
               acc_q <= 1'b0;
            end else begin
               s1    <= key_raw[g];
               s2    <= s1;
               acc_q <= (state == PRESS_WAIT) && s2 && (cnt == CNT_MAX);
               case (state)
                  IDLE: begin
                     if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                     end
                  end
                  PRESS_WAIT: begin
                     if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else if (cnt == CNT_MAX) begin
                        state <= PRESSED;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  PRESSED: begin
                     // holding never re-pulses; only a release can leave here
                     if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                     end
                  end
                  RELEASE_WAIT: begin
                     if (s2) begin
                        state <= PRESSED;
                        cnt   <= '0;
                     end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     cnt   <= '0;
                  end
               endcase
            end
         end

         assign acc[g] = acc_q;
      end
   endgenerate

   // Password switch synchronizer.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pw_s1 <= '0;
         pw_s2 <= '0;
      end else begin
         pw_s1 <= Password_raw;
         pw_s2 <= pw_s1;
      end
   end

   // Output stage: single accept pulses and latches Password; a same-edge
   // double accept is reported as Conflict and leaves Password untouched.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Key1     <= 1'b0;
         Key2     <= 1'b0;
         Conflict <= 1'b0;
         Password <= '0;
      end else begin
         Key1     <= acc[0] & ~acc[1];
         Key2     <= acc[1] & ~acc[0];
         Conflict <= &acc;
         if (^acc) Password <= pw_s2;
      end
   end

endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner: directed scenarios plus randomized bouncing buttons,
// compared every cycle against a run-length debounce model of the conditioner.
module tb_key_input_conditioner;

   localparam int D = 4;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Key1_raw = 1'b0;
   logic       Key2_raw = 1'b0;
   logic [3:0] Password_raw = 4'h0;
   logic       Key1, Key2, Conflict;
   logic [3:0] Password;

   key_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .Clk(Clk), .Reset(Reset), .Key1_raw(Key1_raw), .Key2_raw(Key2_raw),
      .Password_raw(Password_raw), .Key1(Key1), .Key2(Key2),
      .Password(Password), .Conflict(Conflict)
   );

   always #5 Clk = ~Clk;

   int n_chk = 0, n_pass = 0, cyc = 0;
   bit started = 0;

   always @(posedge Clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Model: a key's debounced level flips once D consecutive synchronized
   // samples disagree with it; a 0->1 flip is an accept, reported one edge later.
   bit         ka[2], kb[2], deb[2], accp[2], acc[2];
   int         run[2];
   logic [3:0] pa, pb;
   bit         ek1, ek2, ec;
   logic [3:0] epw;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 2; i++) begin
            ka[i] = 0; kb[i] = 0; deb[i] = 0; accp[i] = 0; acc[i] = 0; run[i] = 0;
         end
         pa = 0; pb = 0; ek1 = 0; ek2 = 0; ec = 0; epw = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            acc[i] = 0;
            if (kb[i] != deb[i]) run[i]++;
            else run[i] = 0;
            if (run[i] >= D) begin
               deb[i] = kb[i];
               run[i] = 0;
               acc[i] = kb[i];
            end
         end
         ec  = accp[0] & accp[1];
         ek1 = accp[0] & !ec;
         ek2 = accp[1] & !ec;
         if (accp[0] != accp[1]) epw = pb;
         for (int i = 0; i < 2; i++) begin
            accp[i] = acc[i];
            kb[i]   = ka[i];
         end
         ka[0] = Key1_raw;
         ka[1] = Key2_raw;
         pb = pa;
         pa = Password_raw;
      end
   end

   int n_k1 = 0, n_k2 = 0, n_cf = 0, last_k1 = -1, last_k2 = -1;
   logic [3:0] pw_k1, pw_k2;

   // Per-cycle compare against the model, plus pulse bookkeeping.
   always @(negedge Clk) begin
      if (started) begin
         chk("key1", Key1, ek1);
         chk("key2", Key2, ek2);
         chk("conflict", Conflict, ec);
         chk("password", Password, epw);
      end
      if (Key1 === 1'b1) begin n_k1++; last_k1 = cyc; pw_k1 = Password; end
      if (Key2 === 1'b1) begin n_k2++; last_k2 = cyc; pw_k2 = Password; end
      if (Conflict === 1'b1) n_cf++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge Clk);
         #2;
      end
   endtask

   int t0, b1, b2, bc;
   bit kv[2];
   int h[2];

   initial begin
      // 1: reset, then idle
      step(2);
      Reset = 1'b1;
      started = 1;
      step(10);
      chk("t1_idle_keys", {Key1, Key2, Conflict}, 3'b000);
      chk("t1_idle_pw", Password, 4'h0);

      // 2: single press, latency and password latch
      Password_raw = 4'b1101;
      b1 = n_k1; b2 = n_k2;
      Key1_raw = 1'b1;
      t0 = cyc;
      step(20);
      chk("t2_k1_count", n_k1 - b1, 1);
      chk("t2_k1_latency", last_k1 - t0, 7);
      chk("t2_pw_at_pulse", pw_k1, 4'b1101);
      chk("t2_k2_none", n_k2 - b2, 0);

      // 4: short release while held -> no pulse; full release -> one pulse
      b1 = n_k1;
      Key1_raw = 1'b0; step(2);
      Key1_raw = 1'b1; step(10);
      chk("t4_short_release", n_k1 - b1, 0);
      Key1_raw = 1'b0; step(8);
      Key1_raw = 1'b1; t0 = cyc; step(12);
      chk("t4_repress_count", n_k1 - b1, 1);
      chk("t4_repress_latency", last_k1 - t0, 7);
      Key1_raw = 1'b0; step(8);

      // 3: bounce on Key2 rejected
      b2 = n_k2;
      Key2_raw = 1'b1; step(2);
      Key2_raw = 1'b0; step(2);
      Key2_raw = 1'b1; step(2);
      Key2_raw = 1'b0; step(10);
      chk("t3_bounce", n_k2 - b2, 0);

      // 5: simultaneous accept -> Conflict, Password held
      Password_raw = 4'h7;
      b1 = n_k1; b2 = n_k2; bc = n_cf;
      Key1_raw = 1'b1; Key2_raw = 1'b1;
      step(12);
      chk("t5_conflict", n_cf - bc, 1);
      chk("t5_no_keys", (n_k1 - b1) + (n_k2 - b2), 0);
      chk("t5_pw_held", Password, 4'b1101);
      Key1_raw = 1'b0; Key2_raw = 1'b0; step(8);

      // 6: reset during PRESS_WAIT with Key2 held
      b2 = n_k2;
      Key2_raw = 1'b1; step(3);
      Reset = 1'b0; step(1);
      chk("t6_reset_pw", Password, 4'h0);
      Reset = 1'b1; t0 = cyc; step(12);
      chk("t6_k2_count", n_k2 - b2, 1);
      chk("t6_k2_latency", last_k2 - t0, 7);
      chk("t6_pw_at_pulse", pw_k2, 4'h7);
      Password_raw = 4'h3; step(10);
      chk("t6_pw_stable", Password, 4'h7);
      Key2_raw = 1'b0; step(8);
      Key2_raw = 1'b1; step(12);
      chk("t6_pw_new", Password, 4'h3);
      Key2_raw = 1'b0; step(8);

      // 7: accepts one cycle apart are independent
      b1 = n_k1; b2 = n_k2; bc = n_cf;
      Key1_raw = 1'b1; step(1);
      Key2_raw = 1'b1; step(12);
      chk("t7_k1", n_k1 - b1, 1);
      chk("t7_k2", n_k2 - b2, 1);
      chk("t7_no_conflict", n_cf - bc, 0);
      chk("t7_spacing", last_k2 - last_k1, 1);
      Key1_raw = 1'b0; Key2_raw = 1'b0; step(8);

      // random bouncing buttons, switch changes and occasional reset pulses
      h[0] = 0; h[1] = 0; kv[0] = 0; kv[1] = 0;
      for (int n = 0; n < 3000; n++) begin
         step(1);
         for (int i = 0; i < 2; i++) begin
            if (h[i] == 0) begin
               kv[i] = !kv[i];
               h[i] = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 3) : $urandom_range(4, 15);
            end
            h[i]--;
         end
         Key1_raw = kv[0];
         Key2_raw = kv[1];
         if ($urandom_range(0, 15) == 0) Password_raw = 4'($urandom);
         Reset = ($urandom_range(0, 499) != 0);
      end
      Reset = 1'b1;
      step(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
